// File: rtl/fetch_load_ctrl_pkg.sv
// Shared definitions for the fetch-load sequencer: FSM state encoding,
// UART command bytes and the default end-of-program marker.
package fetch_load_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        RUN,
        STEP,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_load_ctrl_word_assembler.sv
// Collects UART bytes MSB first into a word; word_valid flags the byte
// that completes a word, with the full word presented alongside it.
module word_assembler #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [NBITS-1:0] word,
    output logic             word_valid
);

    // Only the first three bytes need storing; the fourth is the live input.
    logic [NBITS-9:0] shift_q;
    logic [1:0]       count_q;

    assign word       = {shift_q, byte_data};
    assign word_valid = byte_valid && (count_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_valid) begin
            shift_q <= word[NBITS-9:0];
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/fetch_load_ctrl.sv
// Fetch-stage sequencer: loads a program from the debug UART into
// instruction memory, then gates the pipeline in run or single-step mode.
module fetch_load_ctrl
    import fetch_load_ctrl_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               MEM_DEPTH = 256,
    parameter logic [NBITS-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_halt,
    output logic             o_inst_mem_wr_en,
    output logic [NBITS-1:0] o_inst_mem_data,
    output logic [NBITS-1:0] o_inst_mem_addr,
    output logic             o_load_sel,
    output logic             o_cpu_en,
    output logic             o_cpu_rst,
    output logic             o_done,
    output logic             o_error
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_now;
    logic             asm_clear;
    logic             asm_valid;
    logic             word_valid;
    logic [NBITS-1:0] word;

    word_assembler #(.NBITS(NBITS)) u_word_assembler (
        .clk        (i_clk),
        .rst        (i_rst),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (i_rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_now = 1'b0;
        asm_clear = (state_q != LOAD);
        asm_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                asm_valid = i_rx_valid;
                if (word_valid) begin
                    write_now = 1'b1;
                    // idx is held at the last slot rather than wrapped.
                    if (word == HALT_WORD) begin
                        state_d = READY;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ERR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end else if (i_rx_data == CMD_CONT) begin
                        state_d = RUN;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_d = STEP;
                    end
                end
            end
            RUN: begin
                if (i_halt) state_d = DONE;
            end
            STEP: begin
                state_d = i_halt ? DONE : READY;
            end
            DONE: begin
                if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs follow the next state; the write cycle keeps the memory mux
    // and CPU reset asserted even when the load is finishing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_inst_mem_wr_en <= 1'b0;
            o_inst_mem_data  <= '0;
            o_inst_mem_addr  <= '0;
            o_load_sel       <= 1'b0;
            o_cpu_en         <= 1'b0;
            o_cpu_rst        <= 1'b1;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
        end else begin
            o_inst_mem_wr_en <= write_now;
            if (write_now) begin
                o_inst_mem_data <= word;
                o_inst_mem_addr <= NBITS'({idx_q, 2'b00});
            end
            o_load_sel <= (state_d == LOAD) || write_now;
            o_cpu_en   <= (state_d == RUN) || (state_d == STEP);
            o_cpu_rst  <= (state_d == IDLE) || (state_d == LOAD) ||
                          (state_d == ERR) || write_now;
            o_done     <= (state_d == DONE);
            o_error    <= (state_d == ERR);
        end
    end

endmodule

// File: doc/fetch_load_ctrl.md
# fetch_load_ctrl

Sequencer for the instruction-fetch stage: receives a byte stream from the debug UART, assembles 32-bit words, writes them into instruction memory, then gates the pipeline in continuous-run or single-step mode until the CPU reports HALT. It sits between the UART receiver and the fetch stage, driving the instruction-memory write port, its address mux, and the pipeline enable/reset.

## Interface
- NBITS, 32, instruction/data word width
- MEM_DEPTH, 256, instruction memory depth in words (power of two)
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker
- i_clk  in  1  clock; rising edge only
- i_rst  in  1  synchronous, active-high reset
- i_rx_data  in  8  received UART byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_halt  in  1  CPU retired HALT (level, sampled each cycle)
- o_inst_mem_wr_en  out  1  one-cycle write strobe to instruction memory
- o_inst_mem_data  out  NBITS  assembled word
- o_inst_mem_addr  out  NBITS  byte address of the write (word index × 4)
- o_load_sel  out  1  1 = memory address comes from o_inst_mem_addr, 0 = from PC
- o_cpu_en  out  1  pipeline/PC advance enable
- o_cpu_rst  out  1  hold pipeline and PC in reset
- o_done  out  1  program halted
- o_error  out  1  load overflow, sticky

## Operation
- States: IDLE, LOAD, READY, RUN, STEP, DONE, ERR.
- Command bytes: 'L' 0x4C, 'C' 0x43, 'S' 0x53. Other bytes are ignored outside LOAD.
- IDLE: 'L' -> LOAD. Clears word index and byte counter.
- LOAD: every i_rx_valid byte is shifted in, MSB first (first byte -> [31:24]). On the 4th byte, next cycle: o_inst_mem_wr_en=1, data=word, addr=idx<<2; idx increments.
  - If word == HALT_WORD, it is written, then -> READY.
  - If a non-HALT word is written at idx == MEM_DEPTH-1, -> ERR.
- READY: 'C' -> RUN; 'S' -> STEP; 'L' -> LOAD (idx, byte counter cleared).
- RUN: o_cpu_en=1 each cycle. i_halt -> DONE. Bytes are ignored.
- STEP: o_cpu_en=1 for exactly one cycle, then -> READY. If i_halt is sampled in that cycle -> DONE.
- DONE: o_done=1. 'L' -> LOAD.
- ERR: o_error=1. Left only by i_rst.
- o_cpu_rst=1 in IDLE, LOAD and ERR; 0 otherwise. o_load_sel=1 in LOAD only.

## Timing
- All outputs are registered. Reset values: all outputs 0 except o_cpu_rst=1. State IDLE, idx 0, byte counter 0, word register 0.
- Write latency: o_inst_mem_wr_en is asserted in the cycle after the 4th byte's i_rx_valid. Address and data are stable in that same cycle.
- Back-to-back bytes (i_rx_valid every cycle) are accepted without loss; write pulses then occur every 4 cycles.
- Command-to-enable latency: o_cpu_en rises in the cycle after the 'C'/'S' strobe.
- In RUN, i_halt sampled high -> o_cpu_en=0 and o_done=1 from the next cycle.
- If i_halt and i_rx_valid occur in the same cycle in RUN or STEP, halt wins and the byte is dropped.
- i_rst mid-LOAD discards the partial word. The pending write pulse is suppressed and no memory write occurs after reset.
- idx width is clog2(MEM_DEPTH). The address is zero-extended to NBITS. idx never wraps; overflow goes to ERR instead.

## Structure
- Shared package: state encoding, command byte constants (CMD_LOAD, CMD_CONT, CMD_STEP), HALT_WORD default.
- Sub-module `word_assembler`: byte shift register plus 2-bit byte counter, with clear and word_valid pulse outputs.
- FSM, idx counter and output registers live in fetch_load_ctrl.

## Test plan
- Reset, then idle: o_cpu_rst=1, all other outputs 0; random non-'L' bytes cause no state change.
- 'L', then bytes 20 08 00 05, FF FF FF FF: writes 0x20080005 @0x0 and 0xFFFFFFFF @0x4, then READY, o_cpu_rst=0.
- READY + 'S' three times: exactly three single-cycle o_cpu_en pulses. Then 'C' with i_halt raised 10 cycles later: o_cpu_en=0 and o_done=1 on the following cycle.
- MEM_DEPTH=4, load 4 non-HALT words: 4 writes @0x0–0xC, then o_error=1 sticky. A subsequent 'L' is ignored.
- Reset after 2 bytes of a word: no write. Then 'L' + full word: write at addr 0x0 with only the new bytes.
- RUN with i_halt and 'L' in the same cycle: DONE, byte dropped. A later 'L' -> LOAD with idx=0.
